// File: rtl/cpu_trace_emitter.sv
// Serialises one write-back record into an ASCII trace line, one character per accepted cycle.
// First character appears the cycle after accept; characters hold while char_ready is low.
module cpu_trace_emitter #(
   parameter int TIME_W = 14
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_type,
   input  logic [TIME_W-1:0] in_time,
   input  logic [31:0]       in_pc,
   input  logic [4:0]        in_reg,
   input  logic [31:0]       in_addr,
   input  logic [31:0]       in_data,
   output logic [7:0]        char_out,
   output logic              char_valid,
   input  logic              char_ready,
   output logic              line_done
);

   typedef enum logic [3:0] {
      S_IDLE, S_CARET, S_TIME, S_AT, S_PC, S_COLON, S_SP1, S_SYM,
      S_REG, S_ADDR, S_SP2, S_LT, S_EQ, S_SP3, S_DATA, S_HASH
   } state_t;

   typedef struct packed {
      logic        is_mem;
      logic [13:0] stamp;
      logic [31:0] pc;
      logic [4:0]  rd;
      logic [31:0] addr;
      logic [31:0] data;
   } rec_t;

   state_t      state, state_nxt;
   logic [2:0]  idx, idx_nxt;
   rec_t        rec;
   logic [7:0]  char_nxt;
   logic [13:0] t_q;
   logic [4:0]  r_q;
   logic [2:0]  t_digits;
   logic        accept, type_ok, advance;

   assign in_ready = (state == S_IDLE);
   assign accept   = in_valid && in_ready;
   assign type_ok  = (in_type == 2'd1) || (in_type == 2'd2);
   assign advance  = char_valid && char_ready;

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
   endfunction

   always_ff @(posedge clk) begin
      if (accept && type_ok) begin
         rec.is_mem <= (in_type == 2'd2);
         rec.stamp  <= (in_time > TIME_W'(9999)) ? 14'd9999 : 14'(in_time);
         rec.pc     <= in_pc;
         rec.rd     <= in_reg;
         rec.addr   <= in_addr;
         rec.data   <= in_data;
      end
   end

   always_comb begin
      if (rec.stamp >= 14'd1000)     t_digits = 3'd4;
      else if (rec.stamp >= 14'd100) t_digits = 3'd3;
      else if (rec.stamp >= 14'd10)  t_digits = 3'd2;
      else                           t_digits = 3'd1;
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      if (state == S_IDLE) begin
         if (accept && type_ok) state_nxt = S_CARET;
      end else if (advance) begin
         case (state)
            S_CARET: begin state_nxt = S_TIME; idx_nxt = t_digits; end
            S_TIME:  if (idx == 3'd1) state_nxt = S_AT; else idx_nxt = idx - 3'd1;
            S_AT:    begin state_nxt = S_PC; idx_nxt = 3'd7; end
            S_PC:    if (idx == 3'd0) state_nxt = S_COLON; else idx_nxt = idx - 3'd1;
            S_COLON: state_nxt = S_SP1;
            S_SP1:   state_nxt = S_SYM;
            S_SYM: begin
               if (rec.is_mem) begin
                  state_nxt = S_ADDR;
                  idx_nxt   = 3'd7;
               end else begin
                  state_nxt = S_REG;
                  idx_nxt   = (rec.rd >= 5'd10) ? 3'd2 : 3'd1;
               end
            end
            S_REG:   if (idx == 3'd1) state_nxt = S_SP2; else idx_nxt = idx - 3'd1;
            S_ADDR:  if (idx == 3'd0) state_nxt = S_SP2; else idx_nxt = idx - 3'd1;
            S_SP2:   state_nxt = S_LT;
            S_LT:    state_nxt = S_EQ;
            S_EQ:    state_nxt = S_SP3;
            S_SP3:   begin state_nxt = S_DATA; idx_nxt = 3'd7; end
            S_DATA:  if (idx == 3'd0) state_nxt = S_HASH; else idx_nxt = idx - 3'd1;
            S_HASH:  begin state_nxt = S_IDLE; idx_nxt = 3'd0; end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // Digits are selected by the upcoming index because char_out is registered one state ahead.
   always_comb begin
      case (idx_nxt)
         3'd4:    t_q = rec.stamp / 14'd1000;
         3'd3:    t_q = (rec.stamp / 14'd100) % 14'd10;
         3'd2:    t_q = (rec.stamp / 14'd10) % 14'd10;
         default: t_q = rec.stamp % 14'd10;
      endcase
      r_q = (idx_nxt == 3'd2) ? (rec.rd / 5'd10) : (rec.rd % 5'd10);
   end

   always_comb begin
      char_nxt = 8'h00;
      case (state_nxt)
         S_CARET: char_nxt = "^";
         S_TIME:  char_nxt = 8'h30 + {4'h0, t_q[3:0]};
         S_AT:    char_nxt = "@";
         S_PC:    char_nxt = hex_char(rec.pc[{idx_nxt, 2'b00} +: 4]);
         S_COLON: char_nxt = ":";
         S_SP1, S_SP2, S_SP3: char_nxt = " ";
         S_SYM:   char_nxt = rec.is_mem ? "*" : "$";
         S_REG:   char_nxt = 8'h30 + {4'h0, r_q[3:0]};
         S_ADDR:  char_nxt = hex_char(rec.addr[{idx_nxt, 2'b00} +: 4]);
         S_LT:    char_nxt = "<";
         S_EQ:    char_nxt = "=";
         S_DATA:  char_nxt = hex_char(rec.data[{idx_nxt, 2'b00} +: 4]);
         S_HASH:  char_nxt = "#";
         default: char_nxt = 8'h00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         idx        <= 3'd0;
         char_out   <= 8'h00;
         char_valid <= 1'b0;
         line_done  <= 1'b0;
      end else begin
         state      <= state_nxt;
         idx        <= idx_nxt;
         char_out   <= char_nxt;
         char_valid <= (state_nxt != S_IDLE);
         line_done  <= (state == S_HASH) && advance;
      end
   end

endmodule

// File: tb/tb_cpu_trace_emitter.sv
// Directed bench for cpu_trace_emitter: line contents, timing, backpressure, reset and invalid records.
module tb_cpu_trace_emitter;
   localparam int TIME_W = 14;

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic [1:0]        in_type;
   logic [TIME_W-1:0] in_time;
   logic [31:0]       in_pc;
   logic [4:0]        in_reg;
   logic [31:0]       in_addr;
   logic [31:0]       in_data;
   logic [7:0]        char_out;
   logic              char_valid;
   logic              char_ready;
   logic              line_done;

   int checks = 0;
   int errors = 0;

   cpu_trace_emitter #(.TIME_W(TIME_W)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type),
      .in_time(in_time), .in_pc(in_pc), .in_reg(in_reg),
      .in_addr(in_addr), .in_data(in_data),
      .char_out(char_out), .char_valid(char_valid), .char_ready(char_ready),
      .line_done(line_done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_s(input string tag, input string obs, input string exp);
      checks++;
      assert (obs == exp) else begin
         errors++;
         $error("FAIL %s: observed \"%s\" expected \"%s\"", tag, obs, exp);
      end
   endtask

   task automatic line_test(input string tag, input logic [1:0] typ, input logic [13:0] t,
                            input logic [31:0] pc, input logic [4:0] r, input logic [31:0] a,
                            input logic [31:0] d, input string exp, input bit bp);
      string      got = "";
      int         cyc = 0;
      bit         drop = 0, busy_rdy = 0, hold_bad = 0, stall = 0;
      logic [7:0] held = 8'h00;
      logic       cr;
      chk({tag, ".start_rdy"}, 32'(in_ready), 32'd1);
      in_type  = typ;
      in_time  = t;
      in_pc    = pc;
      in_reg   = r;
      in_addr  = a;
      in_data  = d;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      while (line_done !== 1'b1 && cyc < 400) begin
         if (char_valid !== 1'b1) drop = 1;
         if (in_ready !== 1'b0) busy_rdy = 1;
         if (stall && char_out !== held) hold_bad = 1;
         cr = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         char_ready = cr;
         if (cr) got = $sformatf("%s%c", got, char_out);
         stall = !cr;
         held  = char_out;
         tick();
         cyc++;
      end
      char_ready = 1'b1;
      chk_s({tag, ".line"}, got, exp);
      if (!bp) chk({tag, ".cycles"}, 32'(cyc), 32'(exp.len()));
      chk({tag, ".no_drop"}, 32'(drop), 32'd0);
      chk({tag, ".busy"}, 32'(busy_rdy), 32'd0);
      if (bp) chk({tag, ".hold"}, 32'(hold_bad), 32'd0);
      chk({tag, ".line_done"}, 32'(line_done), 32'd1);
      chk({tag, ".end_rdy"}, 32'(in_ready), 32'd1);
      chk({tag, ".end_vld"}, 32'(char_valid), 32'd0);
   endtask

   initial begin
      reset      = 1'b1;
      in_valid   = 1'b0;
      in_type    = 2'd0;
      in_time    = '0;
      in_pc      = '0;
      in_reg     = '0;
      in_addr    = '0;
      in_data    = '0;
      char_ready = 1'b1;
      tick();
      tick();
      chk("rst.in_ready", 32'(in_ready), 32'd1);
      chk("rst.char_valid", 32'(char_valid), 32'd0);
      chk("rst.char_out", 32'(char_out), 32'd0);
      chk("rst.line_done", 32'(line_done), 32'd0);
      reset = 1'b0;
      tick();

      // Invalid record types are dropped silently.
      in_type  = 2'd0;
      in_valid = 1'b1;
      tick();
      chk("inv0.char_valid", 32'(char_valid), 32'd0);
      chk("inv0.in_ready", 32'(in_ready), 32'd1);
      chk("inv0.line_done", 32'(line_done), 32'd0);
      in_type = 2'd3;
      tick();
      in_valid = 1'b0;
      tick();
      chk("inv3.char_valid", 32'(char_valid), 32'd0);
      chk("inv3.in_ready", 32'(in_ready), 32'd1);
      chk("inv3.line_done", 32'(line_done), 32'd0);

      // Back-to-back records: each new record is offered in the line_done cycle.
      line_test("t1", 2'd1, 14'd42, 32'h0000_3000, 5'd5, 32'h0, 32'h0000_abcd,
                "^42@00003000: $5 <= 0000abcd#", 1'b0);
      line_test("t2", 2'd2, 14'd7, 32'h0000_3004, 5'd0, 32'h0000_0010, 32'hdead_beef,
                "^7@00003004: *00000010 <= deadbeef#", 1'b0);
      line_test("t3a", 2'd1, 14'd0, 32'h0000_0100, 5'd31, 32'h0, 32'h1234_5678,
                "^0@00000100: $31 <= 12345678#", 1'b0);
      line_test("t3b", 2'd1, 14'd9999, 32'hffff_ffff, 5'd0, 32'h0, 32'h0,
                "^9999@ffffffff: $0 <= 00000000#", 1'b0);
      line_test("t3c", 2'd2, 14'd12345, 32'h0000_000c, 5'd0, 32'hcafe_f00d, 32'h0000_ffff,
                "^9999@0000000c: *cafef00d <= 0000ffff#", 1'b0);
      line_test("t3d", 2'd1, 14'd100, 32'h0000_0004, 5'd10, 32'h0, 32'h0000_0001,
                "^100@00000004: $10 <= 00000001#", 1'b0);
      tick();
      chk("pulse.line_done", 32'(line_done), 32'd0);
      chk("pulse.char_valid", 32'(char_valid), 32'd0);

      line_test("t4bp", 2'd1, 14'd42, 32'h0000_3000, 5'd5, 32'h0, 32'h0000_abcd,
                "^42@00003000: $5 <= 0000abcd#", 1'b1);
      tick();

      // Reset in the middle of a line abandons it.
      in_type  = 2'd1;
      in_time  = 14'd1234;
      in_pc    = 32'h0000_2000;
      in_reg   = 5'd3;
      in_data  = 32'h0000_0055;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (10) tick();
      chk("t5.mid_vld", 32'(char_valid), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t5.rst_vld", 32'(char_valid), 32'd0);
      chk("t5.rst_rdy", 32'(in_ready), 32'd1);
      chk("t5.rst_char", 32'(char_out), 32'd0);
      tick();
      tick();
      chk("t5.idle_vld", 32'(char_valid), 32'd0);
      chk("t5.idle_done", 32'(line_done), 32'd0);
      line_test("t5new", 2'd1, 14'd1000, 32'h0000_2004, 5'd9, 32'h0, 32'h8000_0000,
                "^1000@00002004: $9 <= 80000000#", 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
